// File: rtl/free_list_pkg.sv
// Shared sizing and types for the rename-backend physical-register free list.
// Pointers carry one extra wrap bit above the array index.
package free_list_pkg;

  localparam int unsigned PRF_DEPTH = 64;
  localparam int unsigned ARF_DEPTH = 32;
  localparam int unsigned FL_DEPTH  = PRF_DEPTH - ARF_DEPTH;
  localparam int unsigned PRF_IDX_W = $clog2(PRF_DEPTH);
  localparam int unsigned FL_IDX_W  = $clog2(FL_DEPTH);
  localparam int unsigned FL_PTR_W  = FL_IDX_W + 1;

  typedef logic [PRF_IDX_W-1:0] prf_idx_t;
  typedef logic [FL_IDX_W-1:0]  fl_idx_t;
  typedef logic [FL_PTR_W-1:0]  fl_ptr_t;

endpackage

// File: rtl/free_list_if.sv
// Allocation channel from the ID stage and return/commit channel from the ROB.
interface id_fl_itf
  import free_list_pkg::*;
  ();

  logic     alloc_req;
  logic     alloc_ready;
  prf_idx_t alloc_preg;

  modport id (
    output alloc_req,
    input  alloc_ready,
    input  alloc_preg
  );

  modport fl (
    input  alloc_req,
    output alloc_ready,
    output alloc_preg
  );

endinterface

interface rob_fl_itf
  import free_list_pkg::*;
  ();

  logic     free_valid;
  prf_idx_t free_preg;
  logic     commit_alloc;

  modport rob (
    output free_valid,
    output free_preg,
    output commit_alloc
  );

  modport fl (
    input free_valid,
    input free_preg,
    input commit_alloc
  );

endinterface

// File: rtl/free_list_checker.sv
// Protocol and invariant assertions for free_list, observing its pointers.
module free_list_checker
  import free_list_pkg::*;
(
  input logic     clk,
  input logic     rst,
  input fl_ptr_t  spec_head,
  input fl_ptr_t  commit_head,
  input fl_ptr_t  tail,
  input logic     free_valid,
  input prf_idx_t free_preg,
  input logic     commit_alloc,
  input logic     alloc_ready,
  input prf_idx_t alloc_preg
);

  localparam logic [FL_PTR_W:0] STORE_MAX = (FL_PTR_W + 1)'(FL_DEPTH);

  logic [PRF_DEPTH-1:0] freed_in_q, freed_in_d;
  fl_ptr_t              spec_dist_s, tail_dist_s;
  logic [FL_PTR_W:0]    store_next_s;

  // Distances from the committed head and the stored count after this cycle.
  always_comb begin
    spec_dist_s  = spec_head - commit_head;
    tail_dist_s  = tail - commit_head;
    store_next_s = {1'b0, tail_dist_s} + {{FL_PTR_W{1'b0}}, free_valid}
                 - {{FL_PTR_W{1'b0}}, commit_alloc};
    freed_in_d   = freed_in_q;
    if (free_valid) begin
      freed_in_d[free_preg] = 1'b1;
    end else begin
      freed_in_d = freed_in_q;
    end
  end

  // Remembers which pregs have ever been handed back since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      freed_in_q <= {PRF_DEPTH{1'b0}};
    end else begin
      freed_in_q <= freed_in_d;
    end
  end

  a_ptr_order: assert property (@(posedge clk) disable iff (rst)
    (spec_dist_s <= tail_dist_s) && (tail_dist_s <= fl_ptr_t'(FL_DEPTH)));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    free_valid |-> (store_next_s <= STORE_MAX));

  a_preg_range: assert property (@(posedge clk) disable iff (rst)
    alloc_ready |-> ((alloc_preg >= prf_idx_t'(ARF_DEPTH)) || freed_in_q[alloc_preg]));

endmodule

// File: rtl/free_list.sv
// Circular free list of physical registers with a speculative head for
// allocation and a committed head that a backend flush rolls back to.
module free_list
  import free_list_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  id_fl_itf.fl  id_if,
  rob_fl_itf.fl rob_if,
  input  logic  backend_flush
);

  localparam fl_ptr_t PTR_ZERO = {FL_PTR_W{1'b0}};
  localparam fl_ptr_t PTR_ONE  = {{FL_IDX_W{1'b0}}, 1'b1};
  localparam fl_ptr_t PTR_FULL = {1'b1, {FL_IDX_W{1'b0}}};

  prf_idx_t entry_q [FL_DEPTH];
  prf_idx_t entry_d [FL_DEPTH];
  fl_ptr_t  spec_head_q, spec_head_d;
  fl_ptr_t  commit_head_q, commit_head_d;
  fl_ptr_t  tail_q, tail_d;

  logic     empty_s;
  logic     alloc_ready_s;
  logic     alloc_fire_s;
  prf_idx_t alloc_preg_s;

  // Wrapped distance from one pointer to another; equal pointers mean zero.
  function automatic fl_ptr_t ptr_dist(input fl_ptr_t from_ptr, input fl_ptr_t to_ptr);
    return to_ptr - from_ptr;
  endfunction

  // Grant side: current head entry is offered with no added latency.
  always_comb begin
    empty_s        = (ptr_dist(spec_head_q, tail_q) == PTR_ZERO);
    alloc_ready_s  = ~empty_s & ~backend_flush;
    alloc_fire_s   = id_if.alloc_req & alloc_ready_s;
    alloc_preg_s   = entry_q[spec_head_q[FL_IDX_W-1:0]];
    id_if.alloc_ready = alloc_ready_s;
    id_if.alloc_preg  = alloc_preg_s;
  end

  // Speculative head: flush rewinds to the committed head, counting a commit in the same cycle.
  always_comb begin
    spec_head_d = spec_head_q;
    if (backend_flush) begin
      spec_head_d = commit_head_q + (rob_if.commit_alloc ? PTR_ONE : PTR_ZERO);
    end else if (alloc_fire_s) begin
      spec_head_d = spec_head_q + PTR_ONE;
    end else begin
      spec_head_d = spec_head_q;
    end
  end

  // Committed head advances once per committed allocation.
  always_comb begin
    commit_head_d = commit_head_q;
    if (rob_if.commit_alloc) begin
      commit_head_d = commit_head_q + PTR_ONE;
    end else begin
      commit_head_d = commit_head_q;
    end
  end

  // Returned pregs are appended at the tail; a freed preg is visible only from the next cycle.
  always_comb begin
    entry_d = entry_q;
    tail_d  = tail_q;
    if (rob_if.free_valid) begin
      entry_d[tail_q[FL_IDX_W-1:0]] = rob_if.free_preg;
      tail_d = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end
  end

  // State registers; reset refills the list with every unmapped preg.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FL_DEPTH); i++) begin
        entry_q[i] <= prf_idx_t'(ARF_DEPTH + i);
      end
      spec_head_q   <= PTR_ZERO;
      commit_head_q <= PTR_ZERO;
      tail_q        <= PTR_FULL;
    end else begin
      entry_q       <= entry_d;
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: stimulus queues hand-computed grants, a
// negedge monitor compares grants, alloc_ready and grant uniqueness.
module tb_free_list;
  import free_list_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic backend_flush;

  id_fl_itf  id_if ();
  rob_fl_itf rob_if ();

  free_list dut (
    .clk           (clk),
    .rst           (rst),
    .id_if         (id_if),
    .rob_if        (rob_if),
    .backend_flush (backend_flush)
  );

  free_list_checker chk (
    .clk          (clk),
    .rst          (rst),
    .spec_head    (dut.spec_head_q),
    .commit_head  (dut.commit_head_q),
    .tail         (dut.tail_q),
    .free_valid   (rob_if.free_valid),
    .free_preg    (rob_if.free_preg),
    .commit_alloc (rob_if.commit_alloc),
    .alloc_ready  (id_if.alloc_ready),
    .alloc_preg   (id_if.alloc_preg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_grant_q [$];
  int spec_q [$];
  int pool_q [$];
  bit held [PRF_DEPTH];
  int n_store;
  int n_alloc;

  // Monitor: tracks list occupancy and ownership, compares every cycle.
  always @(negedge clk) begin
    logic exp_rdy;
    int   g;
    int   e;
    if (rst) begin
      n_store = int'(FL_DEPTH);
      n_alloc = 0;
      spec_q.delete();
      pool_q.delete();
      for (int i = 0; i < int'(PRF_DEPTH); i++) held[i] = (i < int'(ARF_DEPTH));
      for (int i = 0; i < int'(ARF_DEPTH); i++) pool_q.push_back(i);
    end else begin
      exp_rdy = ((n_store - n_alloc) != 0) && !backend_flush;
      checks++;
      if (id_if.alloc_ready !== exp_rdy) begin
        errors++;
        $display("FAIL alloc_ready: got %0b expected %0b (t=%0t)", id_if.alloc_ready, exp_rdy, $time);
      end
      if (id_if.alloc_req === 1'b1 && id_if.alloc_ready === 1'b1) begin
        g = int'(id_if.alloc_preg);
        checks++;
        if (held[g]) begin
          errors++;
          $display("FAIL dup_grant: got preg %0d still held, expected an unheld preg (t=%0t)", g, $time);
        end
        held[g] = 1'b1;
        spec_q.push_back(g);
        n_alloc++;
        if (exp_grant_q.size() > 0) begin
          e = exp_grant_q.pop_front();
          checks++;
          if (g != e) begin
            errors++;
            $display("FAIL grant_order: got %0d expected %0d (t=%0t)", g, e, $time);
          end
        end
      end
      if (rob_if.commit_alloc) begin
        if (spec_q.size() > 0) pool_q.push_back(spec_q.pop_front());
        n_alloc--;
        n_store--;
      end
      if (backend_flush) begin
        while (spec_q.size() > 0) held[spec_q.pop_front()] = 1'b0;
        n_alloc = 0;
      end
      if (rob_if.free_valid) begin
        held[int'(rob_if.free_preg)] = 1'b0;
        n_store++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_if.alloc_req     = 1'b0;
    rob_if.free_valid   = 1'b0;
    rob_if.free_preg    = '0;
    rob_if.commit_alloc = 1'b0;
    backend_flush       = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) exp_grant_q.push_back(p);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_grant_q.size() != 0) begin
      errors++;
      $display("FAIL drained_%s: got %0d grants outstanding, expected 0", name, exp_grant_q.size());
      exp_grant_q.delete();
    end
  endtask

  task automatic alloc_then_commit(input int n_allocs, input int n_commits);
    push_range(int'(ARF_DEPTH), int'(ARF_DEPTH) + n_allocs - 1);
    id_if.alloc_req = 1'b1;
    repeat (n_allocs) tick();
    id_if.alloc_req = 1'b0;
    rob_if.commit_alloc = 1'b1;
    repeat (n_commits) tick();
    rob_if.commit_alloc = 1'b0;
  endtask

  task automatic rand_cycle();
    logic c;
    logic f;
    int   idx;
    id_if.alloc_req = ($urandom_range(0, 3) != 0);
    c = (n_alloc > 0) && ($urandom_range(0, 2) == 0);
    f = (pool_q.size() > 0) && ((n_store + 1 - int'(c)) <= int'(FL_DEPTH))
        && ($urandom_range(0, 1) == 1);
    backend_flush       = ($urandom_range(0, 19) == 0);
    rob_if.commit_alloc = c;
    rob_if.free_valid   = f;
    rob_if.free_preg    = '0;
    if (f) begin
      idx = int'($urandom_range(0, pool_q.size() - 1));
      rob_if.free_preg = prf_idx_t'(pool_q[idx]);
      pool_q.delete(idx);
    end
    tick();
  endtask

  task automatic scenario_fill();
    push_range(32, 63);
    id_if.alloc_req = 1'b1;
    repeat (35) tick();
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();

    // 1: drain a full list, ready stays low, then commit everything
    do_reset();
    scenario_fill();
    rob_if.commit_alloc = 1'b1;
    repeat (32) tick();
    rob_if.commit_alloc = 1'b0;
    check_drained("t1");

    // 2: free into an empty list, grant only on the following cycle
    exp_grant_q.push_back(5);
    rob_if.free_valid = 1'b1;
    rob_if.free_preg  = prf_idx_t'(5);
    tick();
    rob_if.free_valid = 1'b0;
    tick();
    idle();
    tick();
    check_drained("t2");

    // 3: alloc+free every cycle on a full list; freed 7s follow 32..63
    do_reset();
    push_range(32, 63);
    repeat (68) exp_grant_q.push_back(7);
    id_if.alloc_req = 1'b1;
    tick();
    rob_if.free_valid   = 1'b1;
    rob_if.free_preg    = prf_idx_t'(7);
    rob_if.commit_alloc = 1'b1;
    repeat (99) tick();
    idle();
    check_drained("t3");

    // 4: allocate 10, commit 4, flush -> 36..63 remain
    do_reset();
    alloc_then_commit(10, 4);
    backend_flush = 1'b1;
    tick();
    backend_flush = 1'b0;
    push_range(36, 63);
    id_if.alloc_req = 1'b1;
    repeat (29) tick();
    idle();
    check_drained("t4");

    // 5: flush with a coincident commit and free of preg 2
    do_reset();
    alloc_then_commit(10, 4);
    backend_flush       = 1'b1;
    rob_if.commit_alloc = 1'b1;
    rob_if.free_valid   = 1'b1;
    rob_if.free_preg    = prf_idx_t'(2);
    id_if.alloc_req     = 1'b1;
    tick();
    idle();
    push_range(37, 63);
    exp_grant_q.push_back(2);
    id_if.alloc_req = 1'b1;
    repeat (29) tick();
    idle();
    check_drained("t5");

    // 6: random traffic, reset mid-stream, then the fill sequence repeats
    do_reset();
    repeat (250) rand_cycle();
    rst = 1'b1;
    repeat (2) rand_cycle();
    rst = 1'b0;
    idle();
    scenario_fill();
    idle();
    tick();
    check_drained("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
